// File: rtl/ddr_step_sequencer.sv
// rtl/ddr_step_sequencer.sv - chart reader that walks a step ROM and emits timed arrow events
//
// Walks an arrow chart held in an external synchronous ROM and emits one step
// event per non-empty entry, spaced by the per-entry delay in chart ticks.
//
// Ports:
//   clock          - single clock domain
//   reset          - asynchronous, active-high; clears all state
//   start          - level; starts (or restarts) the chart from address 0 in IDLE/DONE
//   pause          - level; freezes every counter and the FSM while high
//   rom_addr       - registered chart ROM read address
//   rom_data       - chart entry, [7:4] arrow mask, [3:0] delay in ticks
//   step_valid     - one-cycle pulse per emitted step
//   step_arrows    - mask of the last emitted step
//   window_open    - hit window active
//   window_arrows  - mask the judge scores against
//   chart_done     - chart finished
//   tick_count     - ticks since start, saturating
module ddr_step_sequencer #(
    parameter int TICK_DIV   = 3125000,
    parameter int ADDR_W     = 8,
    parameter int HIT_WINDOW = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              step_valid,
    output logic [3:0]        step_arrows,
    output logic              window_open,
    output logic [3:0]        window_arrows,
    output logic              chart_done,
    output logic [15:0]       tick_count
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WIN_W = (HIT_WINDOW > 0) ? $clog2(HIT_WINDOW + 1) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(HIT_WINDOW);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EMIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [3:0]        delay_q, delay_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [3:0]        step_arrows_q, step_arrows_d;
    logic [3:0]        win_arrows_q, win_arrows_d;
    logic [15:0]       tick_count_q, tick_count_d;
    logic              step_valid_q, step_valid_d;
    logic              window_open_q, window_open_d;
    logic              chart_done_q, chart_done_d;

    logic running;
    logic tick;
    logic advance;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        pre_d         = pre_q;
        delay_d       = delay_q;
        win_d         = win_q;
        step_arrows_d = step_arrows_q;
        win_arrows_d  = win_arrows_q;
        tick_count_d  = tick_count_q;
        advance       = 1'b0;

        running = (state_q inside {S_FETCH, S_LATCH, S_EMIT, S_HOLD});
        tick    = running && (pre_q == PRE_LAST);

        // Pause stalls everything, including pending transitions; nothing
        // below runs while it is high.
        if (!pause) begin
            if (running) begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (tick) begin
                    if (tick_count_q != 16'hFFFF) begin
                        tick_count_d = tick_count_q + 16'd1;
                    end
                    if (win_q != '0) begin
                        win_d = win_q - 1'b1;
                    end
                    if (delay_q != 4'd0) begin
                        delay_d = delay_q - 4'd1;
                    end
                end
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d      = S_FETCH;
                        addr_d       = '0;
                        pre_d        = '0;
                        tick_count_d = '0;
                    end
                end
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    if (rom_data == 8'h00) begin
                        state_d = S_DONE;
                    end else begin
                        // Both steps and rests restart the tick phase so that
                        // the delay is measured from this entry.
                        delay_d = rom_data[3:0];
                        pre_d   = '0;
                        if (rom_data[7:4] == 4'h0) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d       = S_EMIT;
                            step_arrows_d = rom_data[7:4];
                            win_arrows_d  = rom_data[7:4];
                            win_d         = WIN_LOAD;
                        end
                    end
                end
                // The exit decision uses the delay as it stood at the start of
                // the cycle, giving d*TICK_DIV + 3 cycles between emits.
                S_EMIT: begin
                    if (delay_q == 4'd0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: advance = (delay_q == 4'd0);
                default: state_d = S_IDLE;
            endcase

            if (advance) begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    addr_d  = addr_q + 1'b1;
                end
            end
        end

        step_valid_d  = (state_d == S_EMIT);
        window_open_d = (win_d != '0);
        chart_done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            pre_q         <= '0;
            delay_q       <= 4'd0;
            win_q         <= '0;
            step_arrows_q <= 4'd0;
            win_arrows_q  <= 4'd0;
            tick_count_q  <= 16'd0;
            step_valid_q  <= 1'b0;
            window_open_q <= 1'b0;
            chart_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            pre_q         <= pre_d;
            delay_q       <= delay_d;
            win_q         <= win_d;
            step_arrows_q <= step_arrows_d;
            win_arrows_q  <= win_arrows_d;
            tick_count_q  <= tick_count_d;
            step_valid_q  <= step_valid_d;
            window_open_q <= window_open_d;
            chart_done_q  <= chart_done_d;
        end
    end

    // A pause landing on the emit cycle holds the FSM in EMIT; the pulse is
    // masked until release so it is seen exactly once, never during pause.
    assign step_valid    = step_valid_q & ~pause;
    assign rom_addr      = addr_q;
    assign step_arrows   = step_arrows_q;
    assign window_open   = window_open_q;
    assign window_arrows = win_arrows_q;
    assign chart_done    = chart_done_q;
    assign tick_count    = tick_count_q;

endmodule

// File: tb/tb_ddr_step_sequencer.sv
// tb/tb_ddr_step_sequencer.sv - self-checking bench for ddr_step_sequencer
module tb_ddr_step_sequencer;

    localparam int T     = 4;
    localparam int HW    = 2;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int MAXC  = 1024;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          step_valid;
    logic [3:0]    step_arrows;
    logic          window_open;
    logic [3:0]    window_arrows;
    logic          chart_done;
    logic [15:0]   tick_count;

    logic [7:0] rom [DEPTH];

    int errors = 0;
    int checks = 0;

    // Model state carried from one chart run to the next (cleared by reset).
    int         prev_left;
    logic [3:0] prev_step;
    logic [3:0] prev_win;

    // Observations of the most recent run.
    int         m_emits;
    int         m_win_cycles;
    int         m_emit_c[$];
    logic [3:0] m_emit_m[$];

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    ddr_step_sequencer #(.TICK_DIV(T), .ADDR_W(AW), .HIT_WINDOW(HW)) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .step_valid(step_valid), .step_arrows(step_arrows),
        .window_open(window_open), .window_arrows(window_arrows),
        .chart_done(chart_done), .tick_count(tick_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qc(input int idx);
        return (idx < m_emit_c.size()) ? m_emit_c[idx] : -1;
    endfunction

    function automatic int qm(input int idx);
        return (idx < m_emit_m.size()) ? int'(m_emit_m[idx]) : -1;
    endfunction

    task automatic load_rom(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'h00;
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        repeat (2) @(negedge clock);
        reset     = 1'b0;
        prev_left = 0;
        prev_step = 4'h0;
        prev_win  = 4'h0;
    endtask

    // Plays the current ROM from a start pulse and compares every cycle with a
    // schedule computed from the chart rules: entry fetched at f is acted on at
    // f+2, the next fetch follows at f+2+d*T+1, ticks fall every T cycles
    // counted from the start and from each step or rest.
    task automatic run_chart(input bit do_reset);
        int         emit_c[$];
        logic [3:0] emit_m[$];
        int         seg_s[$];
        int         fetch_c[$];
        int         fetch_a[$];
        bit         is_tick[MAXC];
        int         tpre[MAXC+1];
        int         f, a, e, nxt, done, last_e, seg_end, cnt, k_emit, k_fetch, cur_addr;
        logic [7:0] v;
        logic [3:0] cur_step, cur_win;
        bit         exp_sv;

        if (do_reset) apply_reset();

        f = 0; a = 0; done = -1;
        seg_s.push_back(0);
        while (done < 0) begin
            fetch_c.push_back(f);
            fetch_a.push_back(a);
            v = rom[a];
            e = f + 2;
            if (v == 8'h00) begin
                done = e;
            end else begin
                if (v[7:4] != 4'h0) begin
                    emit_c.push_back(e);
                    emit_m.push_back(v[7:4]);
                end
                seg_s.push_back(e);
                nxt = e + int'(v[3:0]) * T + 1;
                if (a == DEPTH - 1) done = nxt;
                else begin
                    a++;
                    f = nxt;
                end
            end
        end
        if (done + 4 >= MAXC) begin
            $display("FAIL model_range: observed=%0d expected<%0d", done, MAXC);
            $fatal(1);
        end

        for (int i = 0; i < MAXC; i++) is_tick[i] = 1'b0;
        for (int i = 0; i < seg_s.size(); i++) begin
            seg_end = (i + 1 < seg_s.size()) ? seg_s[i+1] : done;
            for (int t = seg_s[i] + T - 1; t < seg_end; t += T) is_tick[t] = 1'b1;
        end
        tpre[0] = 0;
        for (int i = 0; i < MAXC; i++) tpre[i+1] = tpre[i] + int'(is_tick[i]);

        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;

        m_emits = 0; m_win_cycles = 0;
        m_emit_c.delete(); m_emit_m.delete();
        last_e = -1; k_emit = 0; k_fetch = 0; cur_addr = 0; cnt = 0;
        cur_step = prev_step; cur_win = prev_win;
        for (int c = 0; c <= done + 3; c++) begin
            exp_sv = 1'b0;
            if (k_emit < emit_c.size() && emit_c[k_emit] == c) begin
                exp_sv   = 1'b1;
                last_e   = c;
                cur_step = emit_m[k_emit];
                cur_win  = emit_m[k_emit];
                k_emit++;
            end
            while (k_fetch < fetch_c.size() && fetch_c[k_fetch] <= c) begin
                cur_addr = fetch_a[k_fetch];
                k_fetch++;
            end
            if (last_e >= 0) cnt = HW - (tpre[c] - tpre[last_e]);
            else             cnt = prev_left - tpre[c];
            if (cnt < 0) cnt = 0;

            chk("step_valid",    step_valid,    exp_sv);
            chk("step_arrows",   step_arrows,   cur_step);
            chk("window_open",   window_open,   cnt > 0);
            chk("window_arrows", window_arrows, cur_win);
            chk("chart_done",    chart_done,    c >= done);
            chk("rom_addr",      rom_addr,      cur_addr);
            chk("tick_count",    tick_count,    tpre[c]);

            if (step_valid === 1'b1) begin
                m_emits++;
                m_emit_c.push_back(c);
                m_emit_m.push_back(step_arrows);
            end
            if (window_open === 1'b1) m_win_cycles++;
            @(posedge clock);
            #1;
        end
        prev_left = cnt;
        prev_step = cur_step;
        prev_win  = cur_win;
    endtask

    initial begin
        int pause_emits, pause_second, win_at_25;
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'h00;

        // Reset values.
        apply_reset();
        #1;
        chk("rst_step_valid",    step_valid,    0);
        chk("rst_step_arrows",   step_arrows,   0);
        chk("rst_window_open",   window_open,   0);
        chk("rst_window_arrows", window_arrows, 0);
        chk("rst_chart_done",    chart_done,    0);
        chk("rst_tick_count",    tick_count,    0);
        chk("rst_rom_addr",      rom_addr,      0);

        // Basic step.
        load_rom(8'h12, 8'h00, 8'h00);
        run_chart(1'b1);
        chk("basic_emits",   m_emits,      1);
        chk("basic_latency", qc(0),        2);
        chk("basic_mask",    qm(0),        1);
        chk("basic_window",  m_win_cycles, 8);
        chk("basic_addr",    rom_addr,     1);
        chk("basic_done",    chart_done,   1);

        // Spacing, restarted straight from DONE.
        load_rom(8'h23, 8'h41, 8'h00);
        run_chart(1'b0);
        chk("space_gap",   qc(1) - qc(0), 15);
        chk("space_mask0", qm(0), 2);
        chk("space_mask1", qm(1), 4);

        // Simultaneous arrows and zero delay.
        load_rom(8'h30, 8'h83, 8'h00);
        run_chart(1'b0);
        chk("zero_gap",   qc(1) - qc(0), 3);
        chk("zero_mask0", qm(0), 3);
        chk("zero_mask1", qm(1), 8);

        // End of ROM: every entry is a step, no terminator.
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'h11;
        run_chart(1'b0);
        chk("eor_emits", m_emits,    DEPTH);
        chk("eor_addr",  rom_addr,   DEPTH - 1);
        chk("eor_done",  chart_done, 1);

        // Pause for 20 cycles during the 3-tick hold after the first step.
        load_rom(8'h23, 8'h41, 8'h00);
        apply_reset();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        pause_emits = 0; pause_second = -1; win_at_25 = -1;
        for (int c = 0; c <= 46; c++) begin
            pause = (c >= 6 && c <= 25);
            #1;
            if (pause) chk("pause_no_step", step_valid, 0);
            if (c >= 6 && c <= 26) chk("pause_tick_frozen", tick_count, 1);
            if (c == 25) win_at_25 = int'(window_open);
            if (step_valid === 1'b1) begin
                pause_emits++;
                if (pause_emits == 2) pause_second = c;
            end
            @(posedge clock);
            #1;
        end
        pause = 1'b0;
        chk("pause_emits",  pause_emits,  2);
        chk("pause_second", pause_second, 37);
        chk("pause_window", win_at_25,    1);
        chk("pause_done",   chart_done,   1);
        chk("pause_ticks",  tick_count,   4);

        // Reset while the hit window is open, then replay.
        load_rom(8'h12, 8'h00, 8'h00);
        apply_reset();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("mid_window_open", window_open, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_step_valid",    step_valid,    0);
        chk("mid_rst_step_arrows",   step_arrows,   0);
        chk("mid_rst_window_open",   window_open,   0);
        chk("mid_rst_window_arrows", window_arrows, 0);
        chk("mid_rst_chart_done",    chart_done,    0);
        chk("mid_rst_tick_count",    tick_count,    0);
        chk("mid_rst_rom_addr",      rom_addr,      0);
        @(negedge clock);
        reset = 1'b0;
        prev_left = 0; prev_step = 4'h0; prev_win = 4'h0;
        run_chart(1'b0);
        chk("replay_latency", qc(0), 2);
        chk("replay_mask",    qm(0), 1);

        // Start while paused in IDLE must not start the chart.
        apply_reset();
        @(negedge clock);
        pause = 1'b1;
        start = 1'b1;
        repeat (6) @(negedge clock);
        start = 1'b0;
        pause = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("idle_pause_step",  step_valid,  0);
            chk("idle_pause_arrow", step_arrows, 0);
            chk("idle_pause_ticks", tick_count,  0);
        end

        // Random charts, alternating fresh reset and restart from DONE.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [3:0] m, d;
                m = 4'($urandom_range(0, 15));
                d = 4'($urandom_range(0, 5));
                if (m == 4'h0 && d == 4'h0) d = 4'h1;
                rom[i] = {m, d};
                if (i > 0 && $urandom_range(0, 7) == 0) rom[i] = 8'h00;
            end
            run_chart(r % 2 == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
